// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared FSM type, default parameters and address-field helpers for icache_assoc
package icache_pkg;

    // Refill sequencer states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REFILL  = 2'd1,
        INSTALL = 2'd2
    } state_t;

    localparam int DEF_WAYS       = 2;
    localparam int DEF_SET_WIDTH  = 6;
    localparam int DEF_LINE_WIDTH = 2;

    // Word-within-line index: bits [line_width+1:2].
    function automatic logic [31:0] get_word(input logic [31:0] pc, input int line_width);
        return (pc >> 2) & ((32'd1 << line_width) - 32'd1);
    endfunction

    // Set index: the set_width bits directly above the word index.
    function automatic logic [31:0] get_set(input logic [31:0] pc, input int line_width,
                                            input int set_width);
        return (pc >> (line_width + 2)) & ((32'd1 << set_width) - 32'd1);
    endfunction

    // Tag: everything above the set index.
    function automatic logic [31:0] get_tag(input logic [31:0] pc, input int line_width,
                                            input int set_width);
        return pc >> (line_width + set_width + 2);
    endfunction

endpackage

// File: rtl/icache_way.sv
// rtl/icache_way.sv - one way of the set-associative icache: data, tag and valid storage
//
// Ports:
//   clk_in, rst_in         clock, async active-high reset (clears valid bits only)
//   rd_set/rd_word/rd_tag  lookup address fields
//   rd_hit                 valid and tag match at rd_set
//   rd_valid               valid bit at rd_set (used for victim choice)
//   rd_data                data word at rd_set/rd_word
//   data_we/wr_set/wr_word/wr_data   refill data write port
//   tag_we/wr_tag/wr_valid           line install port (writes tag and valid at wr_set)
//   inv_all                clear every valid bit
module icache_way
    import icache_pkg::*;
#(
    parameter int SET_WIDTH  = DEF_SET_WIDTH,
    parameter int LINE_WIDTH = DEF_LINE_WIDTH,
    parameter int TAG_WIDTH  = 32 - 2 - DEF_SET_WIDTH - DEF_LINE_WIDTH
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [SET_WIDTH-1:0]  rd_set,
    input  logic [LINE_WIDTH-1:0] rd_word,
    input  logic [TAG_WIDTH-1:0]  rd_tag,
    output logic                  rd_hit,
    output logic                  rd_valid,
    output logic [31:0]           rd_data,
    input  logic                  data_we,
    input  logic [SET_WIDTH-1:0]  wr_set,
    input  logic [LINE_WIDTH-1:0] wr_word,
    input  logic [31:0]           wr_data,
    input  logic                  tag_we,
    input  logic [TAG_WIDTH-1:0]  wr_tag,
    input  logic                  wr_valid,
    input  logic                  inv_all
);
    localparam int SETS  = 1 << SET_WIDTH;
    localparam int WORDS = 1 << LINE_WIDTH;

    logic [31:0]          data_mem [SETS*WORDS];
    logic [TAG_WIDTH-1:0] tag_mem  [SETS];
    logic [SETS-1:0]      valid;

    // Data and tag arrays carry no reset; only the valid bits matter after reset.
    always_ff @(posedge clk_in) begin
        if (data_we) data_mem[{wr_set, wr_word}] <= wr_data;
        if (tag_we)  tag_mem[wr_set] <= wr_tag;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)       valid <= '0;
        else if (inv_all) valid <= '0;
        else if (tag_we)  valid[wr_set] <= wr_valid;
    end

    assign rd_valid = valid[rd_set];
    assign rd_hit   = rd_valid && (tag_mem[rd_set] == rd_tag);
    assign rd_data  = data_mem[{rd_set, rd_word}];

endmodule

// File: rtl/icache_assoc.sv
// rtl/icache_assoc.sv - N-way set-associative instruction cache with line refill FSM
//
// Optional feature macro: ICACHE_STATS_EN adds saturating hit/miss counters on
// stat_hits / stat_misses.
//
// Ports:
//   clk_in, rst_in, rdy_in       clock, async active-high reset, global enable
//   req_valid, req_pc            fetch request
//   instr_valid, instr_out       hit indication and instruction word (0 when no hit)
//   busy                         refill in progress
//   flush                        invalidate all lines
//   mem_req_valid, mem_req_addr  single outstanding word request to memory
//   mem_resp_valid, mem_resp_data  returned word
//   stat_hits, stat_misses       (ICACHE_STATS_EN only) counters
module icache_assoc
    import icache_pkg::*;
#(
    parameter int WAYS       = DEF_WAYS,
    parameter int SET_WIDTH  = DEF_SET_WIDTH,
    parameter int LINE_WIDTH = DEF_LINE_WIDTH
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        req_valid,
    input  logic [31:0] req_pc,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic        busy,
    input  logic        flush,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
`ifdef ICACHE_STATS_EN
    output logic [31:0] stat_hits,
    output logic [31:0] stat_misses,
`endif
    input  logic [31:0] mem_resp_data
);
    localparam int TAG_WIDTH = 32 - 2 - SET_WIDTH - LINE_WIDTH;
    localparam int WAY_BITS  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int SETS      = 1 << SET_WIDTH;
    localparam int HI_WIDTH  = TAG_WIDTH + SET_WIDTH;

    state_t                state, state_nxt;
    logic [LINE_WIDTH-1:0] cnt;
    logic [HI_WIDTH-1:0]   line_hi;     // {tag, set} of the line being refilled
    logic [WAY_BITS-1:0]   fill_way;
    logic                  fill_used_invalid;
    logic                  flush_pending;
    logic [WAY_BITS-1:0]   vptr [SETS];

    logic [SET_WIDTH-1:0]  req_set;
    logic [LINE_WIDTH-1:0] req_word;
    logic [TAG_WIDTH-1:0]  req_tag;
    logic [SET_WIDTH-1:0]  fill_set;
    logic [TAG_WIDTH-1:0]  fill_tag;

    logic [WAYS-1:0]       way_hit;
    logic [WAYS-1:0]       way_valid;
    logic [31:0]           way_data [WAYS];
    logic                  any_hit;
    logic [31:0]           hit_data;
    logic [WAY_BITS-1:0]   victim;
    logic                  use_invalid;

    logic                  start_refill;
    logic                  refill_we;
    logic                  install_we;
    logic                  flush_now;

    assign req_set  = SET_WIDTH'(get_set(req_pc, LINE_WIDTH, SET_WIDTH));
    assign req_word = LINE_WIDTH'(get_word(req_pc, LINE_WIDTH));
    assign req_tag  = TAG_WIDTH'(get_tag(req_pc, LINE_WIDTH, SET_WIDTH));
    assign fill_set = line_hi[SET_WIDTH-1:0];
    assign fill_tag = line_hi[HI_WIDTH-1:SET_WIDTH];

    assign flush_now    = rdy_in && flush;
    assign refill_we    = rdy_in && (state == REFILL) && mem_resp_valid;
    assign install_we   = rdy_in && (state == INSTALL);
    assign any_hit      = |way_hit;
    // Flush wins over a miss in the same cycle.
    assign start_refill = rdy_in && (state == IDLE) && req_valid && !any_hit && !flush;

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        icache_way #(
            .SET_WIDTH  (SET_WIDTH),
            .LINE_WIDTH (LINE_WIDTH),
            .TAG_WIDTH  (TAG_WIDTH)
        ) u_way (
            .clk_in   (clk_in),
            .rst_in   (rst_in),
            .rd_set   (req_set),
            .rd_word  (req_word),
            .rd_tag   (req_tag),
            .rd_hit   (way_hit[g]),
            .rd_valid (way_valid[g]),
            .rd_data  (way_data[g]),
            .data_we  (refill_we && (fill_way == WAY_BITS'(g))),
            .wr_set   (fill_set),
            .wr_word  (cnt),
            .wr_data  (mem_resp_data),
            .tag_we   (install_we && (fill_way == WAY_BITS'(g))),
            .wr_tag   (fill_tag),
            .wr_valid (!flush_pending && !flush_now),
            .inv_all  (flush_now)
        );
    end

    // Hit mux and victim choice: lowest invalid way, else the set's round-robin pointer.
    always_comb begin
        hit_data    = '0;
        victim      = vptr[req_set];
        use_invalid = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_hit[w]) hit_data = hit_data | way_data[w];
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!way_valid[w]) begin
                victim      = WAY_BITS'(w);
                use_invalid = 1'b1;
            end
        end
    end

    assign instr_valid  = req_valid && (state == IDLE) && any_hit && !flush;
    assign instr_out    = instr_valid ? hit_data : 32'd0;
    assign mem_req_addr = {line_hi, cnt, 2'b00};

    always_comb begin
        state_nxt     = state;
        busy          = (state != IDLE);
        mem_req_valid = 1'b0;
        case (state)
            IDLE:    if (start_refill) state_nxt = REFILL;
            REFILL: begin
                mem_req_valid = 1'b1;
                if (mem_resp_valid && (&cnt)) state_nxt = INSTALL;
            end
            INSTALL: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state             <= IDLE;
            cnt               <= '0;
            line_hi           <= '0;
            fill_way          <= '0;
            fill_used_invalid <= 1'b0;
            flush_pending     <= 1'b0;
        end else if (rdy_in) begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start_refill) begin
                        line_hi           <= req_pc[31:LINE_WIDTH+2];
                        cnt               <= '0;
                        fill_way          <= victim;
                        fill_used_invalid <= use_invalid;
                    end
                end
                REFILL: begin
                    if (mem_resp_valid && !(&cnt)) cnt <= cnt + LINE_WIDTH'(1);
                    // The in-flight line predates the flush, so it must land invalid.
                    if (flush) flush_pending <= 1'b1;
                end
                INSTALL: flush_pending <= 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int s = 0; s < SETS; s++) vptr[s] <= '0;
        end else if (install_we && !fill_used_invalid) begin
            vptr[fill_set] <= (vptr[fill_set] == WAY_BITS'(WAYS - 1)) ? '0
                              : vptr[fill_set] + WAY_BITS'(1);
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (instr_valid && rdy_in && (hit_cnt != 32'hFFFF_FFFF))  hit_cnt  <= hit_cnt + 32'd1;
            if (start_refill && (miss_cnt != 32'hFFFF_FFFF))          miss_cnt <= miss_cnt + 32'd1;
        end
    end

    assign stat_hits   = hit_cnt;
    assign stat_misses = miss_cnt;
`endif

endmodule

// File: tb/tb_icache_assoc.sv
// tb/tb_icache_assoc.sv - self-checking bench for icache_assoc
module tb_icache_assoc;
    localparam int WAYS = 2;
    localparam int SETS = 64;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        req_valid;
    logic [31:0] req_pc;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic        busy;
    logic        flush;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
`ifdef ICACHE_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;
`endif

    icache_assoc #(.WAYS(WAYS), .SET_WIDTH(6), .LINE_WIDTH(2)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .req_valid      (req_valid),
        .req_pc         (req_pc),
        .instr_valid    (instr_valid),
        .instr_out      (instr_out),
        .busy           (busy),
        .flush          (flush),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
`ifdef ICACHE_STATS_EN
        .stat_hits      (stat_hits),
        .stat_misses    (stat_misses),
`endif
        .mem_resp_data  (mem_resp_data)
    );

    always #5 clk_in = ~clk_in;

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0BAD_F00D;
    endfunction

    // Memory responder: automatic mode answers each request after mem_lat idle cycles.
    bit          mem_auto = 1'b1;
    int          mem_lat  = 3;
    logic        auto_valid, man_valid;
    logic [31:0] auto_data, man_data;
    logic [31:0] req_log[$];
    int          wait_cnt;

    assign mem_resp_valid = mem_auto ? auto_valid : man_valid;
    assign mem_resp_data  = mem_auto ? auto_data  : man_data;

    initial begin
        auto_valid = 1'b0;
        auto_data  = '0;
        wait_cnt   = 0;
        forever begin
            @(posedge clk_in); #1;
            auto_valid = 1'b0;
            if (mem_auto && mem_req_valid && !rst_in) begin
                if (wait_cnt >= mem_lat) begin
                    auto_valid = 1'b1;
                    auto_data  = mem_word(mem_req_addr);
                    req_log.push_back(mem_req_addr);
                    wait_cnt   = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Reference model: which lines each way holds, per-set round-robin pointer.
    bit          m_valid [WAYS][SETS];
    int unsigned m_tag   [WAYS][SETS];
    int          m_ptr   [SETS];

    function automatic int set_of(input logic [31:0] pc);
        return int'((pc >> 4) % SETS);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc >> 10;
    endfunction

    function automatic bit model_lookup(input logic [31:0] pc);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[w][set_of(pc)] && m_tag[w][set_of(pc)] == tag_of(pc)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_install(input logic [31:0] pc, input bit v);
        int s = set_of(pc);
        int victim = -1;
        for (int w = 0; w < WAYS; w++)
            if (!m_valid[w][s] && victim < 0) victim = w;
        if (victim < 0) begin
            victim   = m_ptr[s];
            m_ptr[s] = (m_ptr[s] + 1) % WAYS;
        end
        m_valid[victim][s] = v;
        m_tag[victim][s]   = tag_of(pc);
    endtask

    task automatic model_flush();
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++) m_valid[w][s] = 1'b0;
    endtask

    task automatic model_reset();
        model_flush();
        for (int s = 0; s < SETS; s++) m_ptr[s] = 0;
    endtask

    // One fetch; entered and left just after a rising edge.
    task automatic access(input logic [31:0] pc, input bit exp_hit);
        int cyc;
        req_log.delete();
        req_valid = 1'b1;
        req_pc    = pc;
        @(negedge clk_in);
        check("hit_flag", instr_valid, exp_hit);
        if (exp_hit) begin
            check("hit_data", instr_out, mem_word(pc));
            check("hit_no_mem", mem_req_valid, 1'b0);
        end else begin
            cyc = 0;
            while (!instr_valid && cyc < 400) begin
                @(negedge clk_in);
                cyc++;
            end
            check("miss_latency", cyc, 4 * (mem_lat + 1) + 2);
            check("miss_data", instr_out, mem_word(pc));
            check("refill_words", req_log.size(), 4);
            for (int i = 0; i < req_log.size() && i < 4; i++)
                check("refill_addr", req_log[i], (pc & ~32'hF) + 4 * i);
            model_install(pc, 1'b1);
        end
        @(posedge clk_in); #1;
        req_valid = 1'b0;
    endtask

    typedef struct {
        logic [31:0] pc;
        bit          hit;
    } vec_t;

    vec_t tbl[11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          cyc;
        logic [31:0] pc;

        tbl[0]  = '{32'h0000_1000, 1'b0};
        tbl[1]  = '{32'h0000_1008, 1'b1};
        tbl[2]  = '{32'h0000_1400, 1'b0};
        tbl[3]  = '{32'h0000_1000, 1'b1};
        tbl[4]  = '{32'h0000_1404, 1'b1};
        tbl[5]  = '{32'h0000_1800, 1'b0};
        tbl[6]  = '{32'h0000_1400, 1'b1};
        tbl[7]  = '{32'h0000_1000, 1'b0};
        tbl[8]  = '{32'h0000_180C, 1'b1};
        tbl[9]  = '{32'h0000_1400, 1'b0};
        tbl[10] = '{32'h0000_100C, 1'b1};

        rst_in = 1'b1; rdy_in = 1'b1; req_valid = 1'b0; req_pc = '0; flush = 1'b0;
        man_valid = 1'b0; man_data = '0;
        model_reset();
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_instr_valid", instr_valid, 1'b0);
        check("rst_mem_req", mem_req_valid, 1'b0);
`ifdef ICACHE_STATS_EN
        check("rst_stat_hits", stat_hits, 32'd0);
        check("rst_stat_misses", stat_misses, 32'd0);
`endif
        @(negedge clk_in);
        rst_in = 1'b0;
        @(posedge clk_in); #1;

        // Cold miss, spatial hit, two-way fill and round-robin eviction.
        mem_lat = 3;
        foreach (tbl[i]) access(tbl[i].pc, tbl[i].hit);

        // Flush during the second refill word: line lands invalid, held request re-refills.
        req_log.delete();
        req_valid = 1'b1;
        req_pc    = 32'h0000_2040;
        cyc = 0;
        while (req_log.size() < 1 && cyc < 100) begin
            @(negedge clk_in);
            cyc++;
        end
        @(posedge clk_in); #1;
        flush = 1'b1;
        @(posedge clk_in); #1;
        flush = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk_in);
            cyc++;
        end while (busy && cyc < 200);
        check("flush_refill_done", busy, 1'b0);
        check("flush_line_invalid", instr_valid, 1'b0);
        @(negedge clk_in);
        check("flush_rerefill", busy, 1'b1);
        cyc = 0;
        while (!instr_valid && cyc < 200) begin
            @(negedge clk_in);
            cyc++;
        end
        check("flush_final_data", instr_out, mem_word(32'h0000_2040));
        check("flush_total_words", req_log.size(), 8);
        model_install(32'h0000_2040, 1'b0);
        model_flush();
        model_install(32'h0000_2040, 1'b1);
        @(posedge clk_in); #1;
        req_valid = 1'b0;

        // Flush in IDLE beats a hit and a miss in the same cycle.
        req_valid = 1'b1;
        req_pc    = 32'h0000_2040;
        flush     = 1'b1;
        @(negedge clk_in);
        check("flush_prio_iv", instr_valid, 1'b0);
        @(posedge clk_in); #1;
        flush = 1'b0;
        @(negedge clk_in);
        check("flush_prio_idle", busy, 1'b0);
        check("flush_prio_miss", instr_valid, 1'b0);
        req_valid = 1'b0;
        model_flush();
        @(posedge clk_in); #1;

        // rdy_in low for 5 cycles mid-refill with a stray response pulse.
        mem_auto  = 1'b0;
        req_valid = 1'b1;
        req_pc    = 32'h0000_3080;
        @(posedge clk_in); #1;
        check("stall_addr0", mem_req_addr, 32'h0000_3080);
        man_valid = 1'b1;
        man_data  = mem_word(32'h0000_3080);
        @(posedge clk_in); #1;
        man_valid = 1'b0;
        rdy_in    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            check("stall_req_valid", mem_req_valid, 1'b1);
            check("stall_addr_hold", mem_req_addr, 32'h0000_3084);
            @(posedge clk_in); #1;
            man_valid = (i == 1);
            man_data  = 32'hDEAD_BEEF;
        end
        man_valid = 1'b0;
        rdy_in    = 1'b1;
        mem_lat   = 0;
        req_log.delete();
        mem_auto  = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk_in);
            cyc++;
        end while (!instr_valid && cyc < 100);
        check("stall_data", instr_out, mem_word(32'h0000_3080));
        check("stall_words", req_log.size(), 3);
        for (int i = 0; i < req_log.size() && i < 3; i++)
            check("stall_resume_addr", req_log[i], 32'h0000_3084 + 4 * i);
        model_install(32'h0000_3080, 1'b1);
        @(posedge clk_in); #1;
        req_valid = 1'b0;
        access(32'h0000_3084, 1'b1);

        // Async reset between edges during REFILL.
        mem_lat   = 3;
        req_valid = 1'b1;
        req_pc    = 32'h0000_4000;
        @(negedge clk_in);
        check("rst_pre_miss", instr_valid, 1'b0);
        @(posedge clk_in);
        @(negedge clk_in);
        check("rst_pre_busy", busy, 1'b1);
        #2;
        rst_in = 1'b1;
        #1;
        check("async_rst_mem_req", mem_req_valid, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        req_valid = 1'b0;
        #1;
        rst_in = 1'b0;
        model_reset();
        @(posedge clk_in); #1;

        // One miss then seven hit cycles (the miss completion itself is a hit cycle).
        access(32'h0000_3080, 1'b0);
        access(32'h0000_3084, 1'b1);
        access(32'h0000_3088, 1'b1);
        access(32'h0000_308C, 1'b1);
        access(32'h0000_3080, 1'b1);
        access(32'h0000_3084, 1'b1);
        access(32'h0000_3088, 1'b1);
`ifdef ICACHE_STATS_EN
        check("stat_misses", stat_misses, 32'd1);
        check("stat_hits", stat_hits, 32'd7);
`endif

        // Randomized traffic over 3 sets x 4 tags against the model.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                flush = 1'b1;
                @(negedge clk_in);
                check("rand_flush_idle", busy, 1'b0);
                @(posedge clk_in); #1;
                flush = 1'b0;
                model_flush();
            end else begin
                mem_lat = $urandom_range(0, 2);
                pc = ((32'h20 + $urandom_range(0, 3)) << 10) | (($urandom_range(1, 3)) << 4)
                     | (($urandom_range(0, 3)) << 2);
                access(pc, model_lookup(pc));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/icache_assoc.md
Name: icache_assoc

Overview:
- Parametrised N-way set-associative instruction cache with multi-word lines; successor to the direct-mapped single-word icache.
- Sits between the fetch unit and the memory controller.
- Owns its own refill FSM: on a miss it fetches a whole line word-by-word from memory, installs it into a victim way, then serves the held request.
- Supports a global flush, for fence.i or a mispredict-driven reset of the fetch path.

Parameters:
- WAYS, 2, associativity; power of two, 1..8.
- SET_WIDTH, 6, log2 of the number of sets.
- LINE_WIDTH, 2, log2 of words per line (4 words = 16 B).
- TAG_WIDTH, 32-2-SET_WIDTH-LINE_WIDTH, derived tag width (localparam, not overridable).

Ports:
- clk_in  input  1  clock, rising edge.
- rst_in  input  1  reset, asynchronous, active-high.
- rdy_in  input  1  global enable; low freezes all state.
- req_valid  input  1  fetch request present.
- req_pc  input  32  fetch address, word aligned.
- instr_valid  output  1  hit: instr_out is valid this cycle.
- instr_out  output  32  instruction word.
- busy  output  1  refill in progress; no hits served.
- flush  input  1  invalidate all lines.
- mem_req_valid  output  1  memory word request.
- mem_req_addr  output  32  word address requested.
- mem_resp_valid  input  1  memory returns the word for the outstanding request.
- mem_resp_data  input  32  returned word.

Behaviour:
Address split:
- [1:0] ignored.
- word = [LINE_WIDTH+1:2].
- set = next SET_WIDTH bits.
- tag = remaining upper bits.

Storage:
- Per way: data array (sets x words), tag array, valid bit per set.
- Per set: round-robin victim pointer (log2 WAYS bits).

Lookup (combinational):
- hit when req_valid and state==IDLE and some way has valid and matching tag.
- instr_valid = hit; instr_out = data of the hitting way at the requested word.
- When instr_valid is 0, instr_out is don't-care but is driven to 0.

FSM states: IDLE, REFILL, INSTALL.
- IDLE: when req_valid && !hit && !flush, latch line base (req_pc with word and offset bits zeroed), set, tag and victim way, then go to REFILL with word counter 0.
  - Victim = lowest-numbered invalid way if any, else the set's victim pointer.
- REFILL:
  - mem_req_valid=1, mem_req_addr = line base + 4*counter.
  - Exactly one outstanding request; mem_req_valid and the address stay stable until mem_resp_valid.
  - On mem_resp_valid, write mem_resp_data into the victim way's data at the counter index.
  - If counter == 2^LINE_WIDTH-1, go to INSTALL; else increment the counter.
- INSTALL (one cycle):
  - Write the tag; set valid unless flush_pending; advance the victim pointer of that set modulo WAYS (only if no invalid way was used); clear flush_pending; go to IDLE.
  - The held request hits on the following cycle (miss latency = 2^LINE_WIDTH response waits + 2 cycles).
- busy = (state != IDLE).
- The requester may change req_pc during a refill; the refill always completes and is never aborted.

Flush:
- In IDLE, flush clears all valid bits next edge.
- Flush has priority over a miss that cycle: no refill starts and instr_valid is forced to 0.
- During REFILL/INSTALL, flush clears valid bits immediately and sets flush_pending, so the in-flight line is installed invalid.

Reset (async):
- All valid bits 0, state IDLE, counters and victim pointers 0, flush_pending 0.
- mem_req_valid=0, instr_valid=0, busy=0.
- Data/tag arrays are not reset.
- Reset mid-refill abandons it; any late mem_resp_valid is ignored in IDLE.

rdy_in low:
- No state or array updates; mem_resp_valid is ignored.
- Outputs reflect the frozen state.

Optional Feature:
- ICACHE_STATS_EN
  - Defined: two 32-bit saturating counters, hit_cnt and miss_cnt, exposed as output ports stat_hits and stat_misses.
  - hit_cnt increments on each cycle with instr_valid and rdy_in.
  - miss_cnt increments on each IDLE->REFILL transition.
  - Both counters are cleared by reset only.
  - Undefined: no counters and no stat ports.

Decomposition:
- Package icache_pkg:
  - FSM state enum (IDLE/REFILL/INSTALL).
  - Address-field extraction functions (get_tag/get_set/get_word) parametrised by widths.
  - Default parameter constants.
- One sub-module, icache_way: a single way's data, tag and valid storage with read port and write port; it outputs hit and data for the current lookup.
- icache_assoc instantiates WAYS of them via generate, plus the FSM and victim pointers.

Test Plan:
- Cold miss: req_pc=0x1000, memory responds after 3 cycles per word -> four mem requests at 0x1000/04/08/0C, then instr_valid with the word at 0x1000; next request 0x1008 hits in the same cycle.
- Associativity: WAYS=2, fill 0x1000 and 0x1400 (same set, SET_WIDTH=6), then re-request 0x1000 -> both hit, no mem traffic; a third request 0x1800 evicts way 0 (pointer), and 0x1400 still hits.
- Flush during refill: flush asserted in the 2nd REFILL word -> refill completes, and the request to the same pc then misses again and re-refills.
- rdy_in low for 5 cycles mid-refill, with mem_resp_valid pulsed during the stall -> pulse ignored, mem_req_addr held, refill resumes correctly.
- Async reset asserted between clock edges during REFILL -> mem_req_valid and busy drop immediately; a previously cached line misses after reset.
- ICACHE_STATS_EN: 1 miss then 7 hits -> stat_misses=1, stat_hits=7.
